// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and constants for the instruction-cache CAM
//                write path: refill FSM state encoding, CAM flag bit
//                positions, physical word-address type and line alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Refill/flush sequencer states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        IC_FLUSH = 3'd0,
        IC_IDLE  = 3'd1,
        IC_REQ   = 3'd2,
        IC_DATA  = 3'd3,
        IC_DONE  = 3'd4
    } ic_refill_state_t;

    // Bit positions inside the 2-bit CAM flags field.
    localparam int IC_FLAG_VALID = 0;
    localparam int IC_FLAG_FAULT = 1;

    // Widths of the word-address view of the cache: paddr[28:2],
    // index = paddr[11:2], tag = paddr[28:12].
    localparam int IC_PADDR_W = 27;
    localparam int IC_INDEX_W = 10;
    localparam int IC_TAG_W   = 17;

    typedef logic [IC_PADDR_W-1:0] ic_word_paddr_t;

    // Clear the word-within-line bits so the burst starts on a line boundary.
    function automatic ic_word_paddr_t ic_line_align(input ic_word_paddr_t paddr,
                                                     input int             line_words);
        ic_word_paddr_t mask;
        mask = ic_word_paddr_t'(line_words - 1);
        return paddr & ~mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_flush_walker.sv
`default_nettype none
// ============================================================================
//  Module      : icache_flush_walker
//  Description : Index counter that walks every CAM entry once, 0 up to
//                NUM_WORDS-1, one entry per step. Shared by the icache and
//                dcache invalidation sequencers.
//  Ports       : clk      - clock
//                rst_n    - async active-low reset (counter -> 0)
//                i_clear  - synchronous restart at index 0 (wins over step)
//                i_step   - advance to the next entry, wraps after the last
//                o_index  - entry to write this cycle
//                o_last   - o_index is the final entry
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_flush_walker #(
    parameter int NUM_WORDS = 1024,
    parameter int INDEX_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_step,
    output logic [INDEX_W-1:0] o_index,
    output logic               o_last
);

    localparam logic [INDEX_W-1:0] c_last_index = INDEX_W'(NUM_WORDS - 1);

    logic [INDEX_W-1:0] r_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
        end else if (i_clear || (i_step && (r_index == c_last_index))) begin
            r_index <= '0;
        end else if (i_step) begin
            r_index <= r_index + INDEX_W'(1);
        end
    end

    assign o_index = r_index;
    assign o_last  = (r_index == c_last_index);

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Sequences every instruction-cache CAM write: line refills on
//                a fetch1 miss (one burst read of LINE_WORDS words) and full
//                invalidation after reset or on flush_req. Fetch1 stalls on
//                busy while either is outstanding.
//  Ports       : clk_core, reset_n         - clock, async active-low reset
//                miss_req/paddr/ready/done - fetch1 miss handshake
//                flush_req, busy           - invalidate request, stall
//                bus_req/addr/len/ack      - burst read request channel
//                bus_rvalid/rdata/rlast/err- burst read beat channel
//                cam_write_*               - CAM write port (index, data,
//                                            tag, flags strobes)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_WORDS  = 1024
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        miss_req,
    input  logic [26:0] miss_paddr,
    output logic        miss_ready,
    output logic        miss_done,
    input  logic        flush_req,
    output logic        busy,
    output logic        bus_req,
    output logic [26:0] bus_addr,
    output logic [3:0]  bus_len,
    input  logic        bus_ack,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rlast,
    input  logic        bus_err,
    output logic [9:0]  cam_write_index,
    output logic        cam_write_req_data,
    output logic [31:0] cam_write_data,
    output logic        cam_write_req_tag_flags,
    output logic [16:0] cam_write_tag,
    output logic [1:0]  cam_write_flags
);

    localparam logic [3:0] c_beat_mask = 4'(LINE_WORDS - 1);

    ic_refill_state_t        r_state;
    ic_word_paddr_t          r_line;
    logic [3:0]              r_beat;
    logic                    r_err_seen;
    logic                    r_flush_pending;

    logic [IC_INDEX_W-1:0]   w_walk_index;
    logic                    w_walk_last;
    logic                    w_walk_clear;
    logic                    w_fault;
    logic [3:0]              w_beat_next;

    // The walker sits at 0 outside FLUSH, and a flush_req during FLUSH
    // restarts the walk from the first entry.
    assign w_walk_clear = (r_state != IC_FLUSH) || flush_req;

    icache_flush_walker #(
        .NUM_WORDS (NUM_WORDS),
        .INDEX_W   (IC_INDEX_W)
    ) u_flush_walker (
        .clk     (clk_core),
        .rst_n   (reset_n),
        .i_clear (w_walk_clear),
        .i_step  (r_state == IC_FLUSH),
        .o_index (w_walk_index),
        .o_last  (w_walk_last)
    );

    // Once one beat of a burst errors, the rest of that line is marked faulty.
    assign w_fault     = r_err_seen || bus_err;
    assign w_beat_next = (r_beat + 4'd1) & c_beat_mask;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IC_FLUSH;
            r_line          <= '0;
            r_beat          <= '0;
            r_err_seen      <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            case (r_state)
                IC_FLUSH: begin
                    if (!flush_req && w_walk_last) begin
                        r_state <= IC_IDLE;
                    end
                end
                IC_IDLE: begin
                    // A flush colliding with a miss takes priority; the miss
                    // stays un-accepted and is retried by fetch1.
                    if (flush_req || r_flush_pending) begin
                        r_flush_pending <= 1'b0;
                        r_state         <= IC_FLUSH;
                    end else if (miss_req) begin
                        r_line     <= ic_line_align(miss_paddr, LINE_WORDS);
                        r_beat     <= '0;
                        r_err_seen <= 1'b0;
                        r_state    <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (flush_req) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus_ack) begin
                        r_state <= IC_DATA;
                    end
                end
                IC_DATA: begin
                    if (flush_req) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus_rvalid) begin
                        r_beat <= w_beat_next;
                        if (bus_err) begin
                            r_err_seen <= 1'b1;
                        end
                        if (bus_rlast) begin
                            r_state <= IC_DONE;
                        end
                    end
                end
                IC_DONE: begin
                    if (r_flush_pending || flush_req) begin
                        r_flush_pending <= 1'b0;
                        r_state         <= IC_FLUSH;
                    end else begin
                        r_state <= IC_IDLE;
                    end
                end
                default: begin
                    r_state <= IC_FLUSH;
                end
            endcase
        end
    end

    // Outputs are decoded from state and the current beat. They are forced
    // quiet while reset is held: the CAM keeps its contents across reset, so
    // no strobe may fire until the post-reset flush actually starts, and that
    // flush must begin writing in the very first cycle after release.
    always_comb begin
        miss_ready              = 1'b0;
        miss_done               = 1'b0;
        busy                    = 1'b0;
        bus_req                 = 1'b0;
        bus_addr                = '0;
        bus_len                 = '0;
        cam_write_index         = '0;
        cam_write_req_data      = 1'b0;
        cam_write_data          = '0;
        cam_write_req_tag_flags = 1'b0;
        cam_write_tag           = '0;
        cam_write_flags         = '0;
        if (reset_n) begin
            busy = (r_state != IC_IDLE) || r_flush_pending;
            case (r_state)
                IC_FLUSH: begin
                    cam_write_req_tag_flags = 1'b1;
                    cam_write_index         = w_walk_index;
                end
                IC_IDLE: begin
                    miss_ready = !r_flush_pending && !flush_req;
                end
                IC_REQ: begin
                    bus_req  = 1'b1;
                    bus_addr = r_line;
                    bus_len  = c_beat_mask;
                end
                IC_DATA: begin
                    if (bus_rvalid) begin
                        // Line is aligned, so OR-ing the beat never carries
                        // into the tag bits.
                        cam_write_index                  = r_line[IC_INDEX_W-1:0] | IC_INDEX_W'(r_beat);
                        cam_write_req_data               = 1'b1;
                        cam_write_data                   = bus_rdata;
                        cam_write_req_tag_flags          = 1'b1;
                        cam_write_tag                    = r_line[IC_PADDR_W-1 -: IC_TAG_W];
                        cam_write_flags[IC_FLAG_FAULT]   = w_fault;
                        cam_write_flags[IC_FLAG_VALID]   = !w_fault;
                    end
                end
                IC_DONE: begin
                    miss_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Directed self-checking bench for icache_refill_ctrl
//                (LINE_WORDS=4, NUM_WORDS=1024).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic        clk_core = 1'b0;
    logic        reset_n  = 1'b0;
    logic        miss_req;
    logic [26:0] miss_paddr;
    logic        miss_ready;
    logic        miss_done;
    logic        flush_req;
    logic        busy;
    logic        bus_req;
    logic [26:0] bus_addr;
    logic [3:0]  bus_len;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_rlast;
    logic        bus_err;
    logic [9:0]  cam_write_index;
    logic        cam_write_req_data;
    logic [31:0] cam_write_data;
    logic        cam_write_req_tag_flags;
    logic [16:0] cam_write_tag;
    logic [1:0]  cam_write_flags;

    int checks = 0;
    int errors = 0;

    icache_refill_ctrl #(
        .LINE_WORDS (4),
        .NUM_WORDS  (1024)
    ) dut (
        .clk_core                (clk_core),
        .reset_n                 (reset_n),
        .miss_req                (miss_req),
        .miss_paddr              (miss_paddr),
        .miss_ready              (miss_ready),
        .miss_done               (miss_done),
        .flush_req               (flush_req),
        .busy                    (busy),
        .bus_req                 (bus_req),
        .bus_addr                (bus_addr),
        .bus_len                 (bus_len),
        .bus_ack                 (bus_ack),
        .bus_rvalid              (bus_rvalid),
        .bus_rdata               (bus_rdata),
        .bus_rlast               (bus_rlast),
        .bus_err                 (bus_err),
        .cam_write_index         (cam_write_index),
        .cam_write_req_data      (cam_write_req_data),
        .cam_write_data          (cam_write_data),
        .cam_write_req_tag_flags (cam_write_req_tag_flags),
        .cam_write_tag           (cam_write_tag),
        .cam_write_flags         (cam_write_flags)
    );

    always #5 clk_core = ~clk_core;

    // Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_core);
        #2;
    endtask

    task automatic idle_inputs();
        miss_req   = 1'b0;
        miss_paddr = '0;
        flush_req  = 1'b0;
        bus_ack    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_rlast  = 1'b0;
        bus_err    = 1'b0;
    endtask

    // Stimulus only: accept already done, drive ack and 4 clean beats,
    // then step through DONE back to IDLE.
    task automatic drive_burst();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hCAFE_0000 + 32'(b);
            bus_rlast  = (b == 3);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        #1;
        checks++;
        if ({busy, miss_ready, miss_done, bus_req, cam_write_req_tag_flags, cam_write_req_data} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy/rdy/done/breq/tf/rd=%b expected 000000",
                     {busy, miss_ready, miss_done, bus_req, cam_write_req_tag_flags, cam_write_req_data});
        end
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (cam_write_index !== 10'(i) || cam_write_req_tag_flags !== 1'b1 || cam_write_req_data !== 1'b0 ||
                cam_write_flags !== 2'b00 || busy !== 1'b1 || miss_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush[%0d]: idx=%h tf=%b rd=%b flags=%b busy=%b rdy=%b expected idx=%h tf=1 rd=0 flags=00 busy=1 rdy=0",
                         i, cam_write_index, cam_write_req_tag_flags, cam_write_req_data, cam_write_flags, busy, miss_ready, 10'(i));
            end
            tick();
            #1;
        end
        checks++;
        if (miss_ready !== 1'b1 || busy !== 1'b0 || cam_write_req_tag_flags !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b busy=%b tf=%b expected rdy=1 busy=0 tf=0", miss_ready, busy, cam_write_req_tag_flags);
        end
    endtask

    task automatic test_refill_basic();
        // 0x0001234: index = low 10 bits = 0x234, tag = bits [26:10] = 0x4.
        miss_req   = 1'b1;
        miss_paddr = 27'h0001235;
        #1;
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: miss_ready=%b expected 1", miss_ready);
        end
        tick();
        miss_req = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 27'h0001234 || bus_len !== 4'd3 ||
            cam_write_req_tag_flags !== 1'b0 || cam_write_req_data !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req: breq=%b addr=%h len=%h tf=%b rd=%b busy=%b expected 1 0001234 3 0 0 1",
                     bus_req, bus_addr, bus_len, cam_write_req_tag_flags, cam_write_req_data, busy);
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hD000_0000 + 32'(b);
            bus_rlast  = (b == 3);
            #1;
            checks++;
            if (cam_write_index !== 10'h234 + 10'(b) || cam_write_req_data !== 1'b1 || cam_write_req_tag_flags !== 1'b1 ||
                cam_write_data !== 32'hD000_0000 + 32'(b) || cam_write_tag !== 17'h00004 || cam_write_flags !== 2'b01 ||
                bus_req !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat[%0d]: idx=%h rd=%b tf=%b data=%h tag=%h flags=%b breq=%b expected idx=%h 1 1 data=%h tag=00004 flags=01 breq=0",
                         b, cam_write_index, cam_write_req_data, cam_write_req_tag_flags, cam_write_data, cam_write_tag,
                         cam_write_flags, bus_req, 10'h234 + 10'(b), 32'hD000_0000 + 32'(b));
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (miss_done !== 1'b1 || cam_write_req_tag_flags !== 1'b0 || busy !== 1'b1 || miss_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b tf=%b busy=%b rdy=%b expected 1 0 1 0", miss_done, cam_write_req_tag_flags, busy, miss_ready);
        end
        tick();
        #1;
        checks++;
        if (miss_done !== 1'b0 || miss_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: done=%b rdy=%b busy=%b expected 0 1 0", miss_done, miss_ready, busy);
        end
    endtask

    task automatic test_ack_delay_gaps();
        int gaps [4] = '{0, 1, 2, 3};
        int writes;
        writes     = 0;
        // Top of the address space: index 0x3FC..0x3FF, tag all ones.
        miss_req   = 1'b1;
        miss_paddr = 27'h7FFFFFF;
        tick();
        miss_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 27'h7FFFFFC || bus_len !== 4'd3 || cam_write_req_tag_flags !== 1'b0) begin
                errors++;
                $display("FAIL ackwait[%0d]: breq=%b addr=%h len=%h tf=%b expected 1 7fffffc 3 0",
                         k, bus_req, bus_addr, bus_len, cam_write_req_tag_flags);
            end
            tick();
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                bus_rvalid = 1'b0;
                bus_rlast  = 1'b0;
                bus_rdata  = 32'hFFFF_FFFF;
                #1;
                checks++;
                if (cam_write_req_data !== 1'b0 || cam_write_req_tag_flags !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_nowrite[%0d.%0d]: rd=%b tf=%b expected 0 0", b, g, cam_write_req_data, cam_write_req_tag_flags);
                end
                if (cam_write_req_data === 1'b1) writes++;
                tick();
            end
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hA5A5_0000 + 32'(b);
            bus_rlast  = (b == 3);
            #1;
            if (cam_write_req_data === 1'b1) writes++;
            checks++;
            if (cam_write_index !== 10'h3FC + 10'(b) || cam_write_tag !== 17'h1FFFF || cam_write_flags !== 2'b01 ||
                cam_write_data !== 32'hA5A5_0000 + 32'(b)) begin
                errors++;
                $display("FAIL gap_beat[%0d]: idx=%h tag=%h flags=%b data=%h expected idx=%h tag=1ffff flags=01 data=%h",
                         b, cam_write_index, cam_write_tag, cam_write_flags, cam_write_data, 10'h3FC + 10'(b), 32'hA5A5_0000 + 32'(b));
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (writes !== 4 || miss_done !== 1'b1) begin
            errors++;
            $display("FAIL gap_count: writes=%0d done=%b expected 4 1", writes, miss_done);
        end
        tick();
    endtask

    task automatic test_bus_err();
        logic err_tbl [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_flags [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
        // 0x0ABCDE8: index = 0x1E8, tag = 0x2AF3.
        miss_req   = 1'b1;
        miss_paddr = 27'h0ABCDE9;
        tick();
        miss_req = 1'b0;
        bus_ack  = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_rvalid = 1'b1;
            bus_err    = err_tbl[b];
            bus_rdata  = 32'h0BAD_0000 + 32'(b);
            bus_rlast  = (b == 3);
            #1;
            checks++;
            if (cam_write_flags !== exp_flags[b] || cam_write_index !== 10'h1E8 + 10'(b) ||
                cam_write_tag !== 17'h02AF3 || cam_write_req_data !== 1'b1) begin
                errors++;
                $display("FAIL err_beat[%0d]: flags=%b idx=%h tag=%h rd=%b expected flags=%b idx=%h tag=02af3 rd=1",
                         b, cam_write_flags, cam_write_index, cam_write_tag, cam_write_req_data, exp_flags[b], 10'h1E8 + 10'(b));
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (miss_done !== 1'b1) begin
            errors++;
            $display("FAIL err_done: miss_done=%b expected 1", miss_done);
        end
        tick();
    endtask

    task automatic test_flush_collision();
        miss_req   = 1'b1;
        miss_paddr = 27'h0000100;
        flush_req  = 1'b1;
        #1;
        checks++;
        if (miss_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_ready: miss_ready=%b expected 0", miss_ready);
        end
        tick();
        flush_req = 1'b0;
        // Walk 10 entries, then restart the flush while writing entry 10.
        for (int i = 0; i < 11; i++) begin
            flush_req = (i == 10);
            #1;
            checks++;
            if (cam_write_index !== 10'(i) || cam_write_req_tag_flags !== 1'b1 || busy !== 1'b1 || miss_ready !== 1'b0) begin
                errors++;
                $display("FAIL coll_pre[%0d]: idx=%h tf=%b busy=%b rdy=%b expected idx=%h 1 1 0",
                         i, cam_write_index, cam_write_req_tag_flags, busy, miss_ready, 10'(i));
            end
            tick();
        end
        flush_req = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            checks++;
            if (cam_write_index !== 10'(i) || cam_write_req_tag_flags !== 1'b1 || cam_write_flags !== 2'b00 ||
                busy !== 1'b1 || miss_ready !== 1'b0) begin
                errors++;
                $display("FAIL coll_flush[%0d]: idx=%h tf=%b flags=%b busy=%b rdy=%b expected idx=%h 1 00 1 0",
                         i, cam_write_index, cam_write_req_tag_flags, cam_write_flags, busy, miss_ready, 10'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_accept: miss_ready=%b expected 1", miss_ready);
        end
        tick();
        miss_req = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 27'h0000100) begin
            errors++;
            $display("FAIL coll_req: breq=%b addr=%h expected 1 0000100", bus_req, bus_addr);
        end
        drive_burst();
        #1;
        checks++;
        if (miss_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_idle: rdy=%b busy=%b expected 1 0", miss_ready, busy);
        end
    endtask

    task automatic test_flush_during_data();
        miss_req   = 1'b1;
        miss_paddr = 27'h0002468;
        tick();
        miss_req = 1'b0;
        bus_ack  = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h7777_0000 + 32'(b);
            bus_rlast  = (b == 3);
            flush_req  = (b == 1);
            #1;
            checks++;
            if (cam_write_index !== 10'h068 + 10'(b) || cam_write_req_data !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL fdata_beat[%0d]: idx=%h rd=%b busy=%b expected idx=%h 1 1",
                         b, cam_write_index, cam_write_req_data, busy, 10'h068 + 10'(b));
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (miss_done !== 1'b1 || busy !== 1'b1 || cam_write_req_tag_flags !== 1'b0) begin
            errors++;
            $display("FAIL fdata_done: done=%b busy=%b tf=%b expected 1 1 0", miss_done, busy, cam_write_req_tag_flags);
        end
        tick();
        for (int i = 0; i < 1024; i++) begin
            #1;
            checks++;
            if (cam_write_index !== 10'(i) || cam_write_req_tag_flags !== 1'b1 || busy !== 1'b1 || miss_done !== 1'b0) begin
                errors++;
                $display("FAIL fdata_flush[%0d]: idx=%h tf=%b busy=%b done=%b expected idx=%h 1 1 0",
                         i, cam_write_index, cam_write_req_tag_flags, busy, miss_done, 10'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL fdata_idle: busy=%b rdy=%b expected 0 1", busy, miss_ready);
        end
    endtask

    task automatic test_reset_mid_data();
        miss_req   = 1'b1;
        miss_paddr = 27'h0000040;
        tick();
        miss_req = 1'b0;
        bus_ack  = 1'b1;
        tick();
        bus_ack    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_1111;
        #1;
        checks++;
        if (cam_write_req_data !== 1'b1 || cam_write_index !== 10'h040) begin
            errors++;
            $display("FAIL rst_pre: rd=%b idx=%h expected 1 040", cam_write_req_data, cam_write_index);
        end
        tick();
        bus_rdata = 32'h2222_2222;
        reset_n   = 1'b0;
        #1;
        checks++;
        if ({busy, miss_ready, miss_done, bus_req, cam_write_req_tag_flags, cam_write_req_data} !== 6'b0 ||
            cam_write_flags !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: busy/rdy/done/breq/tf/rd=%b flags=%b expected 000000 00",
                     {busy, miss_ready, miss_done, bus_req, cam_write_req_tag_flags, cam_write_req_data}, cam_write_flags);
        end
        tick();
        tick();
        idle_inputs();
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (cam_write_index !== 10'(i) || cam_write_req_tag_flags !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rst_flush[%0d]: idx=%h tf=%b busy=%b expected idx=%h 1 1",
                         i, cam_write_index, cam_write_req_tag_flags, busy, 10'(i));
            end
            tick();
            #1;
        end
        checks++;
        if (miss_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: rdy=%b busy=%b expected 1 0", miss_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_refill_basic();
        test_ack_delay_gaps();
        test_bus_err();
        test_flush_collision();
        test_flush_during_data();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
